// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational next-PC lookup for fetch,
// registered allocation and 2-bit counter training from resolved branches.
module branch_target_buffer #(
   parameter int ENTRIES = 16,
   localparam int IDX_W = $clog2(ENTRIES)
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] fetch_pc,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_npc,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target
);

   localparam int TAG_W = 32 - IDX_W - 2;

   logic             valid_q [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [31:0]      tgt_q   [ENTRIES];
   logic [1:0]       ctr_q   [ENTRIES];
   logic             valid_d [ENTRIES];
   logic [TAG_W-1:0] tag_d   [ENTRIES];
   logic [31:0]      tgt_d   [ENTRIES];
   logic [1:0]       ctr_d   [ENTRIES];

   logic [IDX_W-1:0] fetch_idx_s, upd_idx_s;
   logic [TAG_W-1:0] fetch_tag_s, upd_tag_s;
   logic             upd_hit_s;
   logic [3:0]       unused_pc_bits_s;

   // Weak states collapse to a strong state on either outcome.
   function automatic logic [1:0] next_ctr(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      case (ctr)
         2'b00:   nxt = taken ? 2'b01 : 2'b00;
         2'b01:   nxt = taken ? 2'b11 : 2'b00;
         2'b10:   nxt = taken ? 2'b11 : 2'b00;
         2'b11:   nxt = taken ? 2'b11 : 2'b10;
         default: nxt = 2'b00;
      endcase
      return nxt;
   endfunction

   assign fetch_idx_s      = fetch_pc[IDX_W+1:2];
   assign fetch_tag_s      = fetch_pc[31:IDX_W+2];
   assign upd_idx_s        = upd_pc[IDX_W+1:2];
   assign upd_tag_s        = upd_pc[31:IDX_W+2];
   assign unused_pc_bits_s = {fetch_pc[1:0], upd_pc[1:0]};

   // Lookup sees only registered state, so a same-cycle update is not bypassed.
   always_comb begin
      pred_hit   = valid_q[fetch_idx_s] && (tag_q[fetch_idx_s] == fetch_tag_s);
      pred_taken = pred_hit && ctr_q[fetch_idx_s][1];
      if (pred_taken) begin
         pred_npc = tgt_q[fetch_idx_s];
      end else begin
         pred_npc = fetch_pc + 32'd4;
      end
   end

   // Train on a hit, allocate on a taken miss, ignore a not-taken miss.
   always_comb begin
      valid_d   = valid_q;
      tag_d     = tag_q;
      tgt_d     = tgt_q;
      ctr_d     = ctr_q;
      upd_hit_s = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
      if (upd_en) begin
         if (upd_hit_s) begin
            ctr_d[upd_idx_s] = next_ctr(ctr_q[upd_idx_s], upd_taken);
            if (upd_taken) begin
               tgt_d[upd_idx_s] = upd_target;
            end else begin
               tgt_d[upd_idx_s] = tgt_q[upd_idx_s];
            end
         end else if (upd_taken) begin
            valid_d[upd_idx_s] = 1'b1;
            tag_d[upd_idx_s]   = upd_tag_s;
            tgt_d[upd_idx_s]   = upd_target;
            ctr_d[upd_idx_s]   = 2'b10;
         end else begin
            ctr_d[upd_idx_s] = ctr_q[upd_idx_s];
         end
      end else begin
         ctr_d[upd_idx_s] = ctr_q[upd_idx_s];
      end
   end

   // Entry storage.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= 32'd0;
            ctr_q[i]   <= 2'b00;
         end
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         tgt_q   <= tgt_d;
         ctr_q   <= ctr_d;
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (ENTRIES=16).
module tb_branch_target_buffer;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic [31:0] fetch_pc = 32'd0;
   logic        pred_hit, pred_taken;
   logic [31:0] pred_npc;
   logic        upd_en = 1'b0;
   logic [31:0] upd_pc = 32'd0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = 32'd0;

   int n_cmp = 0;
   int n_err = 0;

   branch_target_buffer #(.ENTRIES(16)) dut (
      .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_npc(pred_npc),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
   );

   always #5 CLK = ~CLK;

   task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      @(negedge CLK);
      upd_en = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
      @(posedge CLK);
      #1;
      upd_en = 1'b0;
   endtask

   task automatic look(input string name, input logic [31:0] pc,
                       input logic hit, input logic tk, input logic [31:0] npc);
      fetch_pc = pc;
      #1;
      n_cmp++;
      if (pred_hit !== hit || pred_taken !== tk || pred_npc !== npc) begin
         n_err++;
         $display("FAIL %s: got hit=%b taken=%b npc=%h, want hit=%b taken=%b npc=%h",
                  name, pred_hit, pred_taken, pred_npc, hit, tk, npc);
      end
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      repeat (2) @(posedge CLK);
      #1 nRST = 1'b1;
      look("reset_miss", 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044);
   endtask

   task automatic test_allocate();
      @(negedge CLK);
      upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100; upd_en = 1'b0;
      @(posedge CLK); #1;
      look("no_upd_en", 32'h40, 1'b0, 1'b0, 32'h44);
      do_update(32'h40, 1'b1, 32'h100);
      look("alloc_hit", 32'h40, 1'b1, 1'b1, 32'h100);
      do_update(32'h180, 1'b0, 32'h700);
      look("nt_miss_no_alloc", 32'h180, 1'b0, 1'b0, 32'h184);
   endtask

   task automatic test_training();
      do_update(32'h40, 1'b0, 32'h999);
      look("ctr_10_to_00", 32'h40, 1'b1, 1'b0, 32'h44);
      do_update(32'h40, 1'b1, 32'h100);
      look("ctr_00_to_01", 32'h40, 1'b1, 1'b0, 32'h44);
      do_update(32'h40, 1'b1, 32'h100);
      look("ctr_01_to_11", 32'h40, 1'b1, 1'b1, 32'h100);
      do_update(32'h40, 1'b0, 32'h555);
      look("ctr_11_to_10_keep_tgt", 32'h40, 1'b1, 1'b1, 32'h100);
      do_update(32'h40, 1'b1, 32'h100);
      do_update(32'h40, 1'b1, 32'h104);
      do_update(32'h40, 1'b0, 32'h0);
      look("ctr_11_sat_new_tgt", 32'h40, 1'b1, 1'b1, 32'h104);
      do_update(32'h40, 1'b1, 32'h100);
   endtask

   task automatic test_alias_evict();
      do_update(32'h80, 1'b1, 32'h200);
      look("evicted_miss", 32'h40, 1'b0, 1'b0, 32'h44);
      look("new_occupant", 32'h80, 1'b1, 1'b1, 32'h200);
      do_update(32'hC4, 1'b0, 32'h300);
      look("idx1_invalid", 32'hC4, 1'b0, 1'b0, 32'hC8);
   endtask

   task automatic test_same_cycle();
      @(negedge CLK);
      fetch_pc = 32'h40;
      upd_en = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h300;
      #1;
      n_cmp++;
      if (pred_hit !== 1'b0 || pred_npc !== 32'h44) begin
         n_err++;
         $display("FAIL same_cycle_old: got hit=%b npc=%h, want hit=0 npc=00000044", pred_hit, pred_npc);
      end
      @(posedge CLK); #1;
      upd_en = 1'b0;
      look("same_cycle_new", 32'h40, 1'b1, 1'b1, 32'h300);
      look("wrap_npc", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);
   endtask

   task automatic test_async_reset();
      look("pre_reset_hit", 32'h40, 1'b1, 1'b1, 32'h300);
      @(negedge CLK);
      upd_en = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1; upd_target = 32'h444;
      #2 nRST = 1'b0;
      #1;
      n_cmp++;
      if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_npc !== 32'h44) begin
         n_err++;
         $display("FAIL async_reset_now: got hit=%b taken=%b npc=%h, want 0 0 00000044",
                  pred_hit, pred_taken, pred_npc);
      end
      @(posedge CLK); #1;
      upd_en = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      look("post_reset_40", 32'h40, 1'b0, 1'b0, 32'h44);
      look("post_reset_80", 32'h80, 1'b0, 1'b0, 32'h84);
   endtask

   initial begin
      test_reset();
      test_allocate();
      test_training();
      test_alias_evict();
      test_same_cycle();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
